// File: rtl/fb_rect_engine_if.sv
// Command and RAM port B bundle for the rectangle fill engine.
// slave = engine side, master = requester plus RAM side.
interface fb_rect_engine_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_x0;
    logic [8:0] cmd_x1;
    logic [7:0] cmd_y0;
    logic [7:0] cmd_y1;
    logic [1:0] cmd_op;
    logic       done;
    logic       err;
    logic [8:0] x_b;
    logic [7:0] y_b;
    logic       read_b;
    logic       write_b;
    logic       in_b;
    logic       out_b;
    logic       rdy_b;

    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_op, out_b, rdy_b,
        input  cmd_ready, done, err, x_b, y_b, read_b, write_b, in_b
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_op, out_b, rdy_b,
        output cmd_ready, done, err, x_b, y_b, read_b, write_b, in_b
    );
endinterface

// File: rtl/fb_rect_engine.sv
// Rectangle clear/set/invert engine walking a 1-bpp framebuffer in raster
// order through a single-pixel RAM port with a ready handshake.
module fb_rect_engine #(
    parameter int FB_W = 320,
    parameter int FB_H = 200
) (
    input logic            clk,
    input logic            reset,
    fb_rect_engine_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, CHECK, READ, RWAIT, WRITE, WWAIT, ADV, FIN
    } state_t;

    state_t     state;
    logic [8:0] x0_r, x1_r;
    logic [7:0] y0_r, y1_r;
    logic [1:0] op_r;
    logic       rdata;
    logic       reject;
    logic       more;

    always_comb begin
        reject = (x0_r > x1_r) || (y0_r > y1_r) ||
                 (32'(x1_r) >= FB_W) || (32'(y1_r) >= FB_H) ||
                 (op_r == 2'd3);
        more   = (bus.x_b < x1_r) || (bus.y_b < y1_r);
    end

    // x_b/y_b double as the raster counters, so they stay put through waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.read_b    <= 1'b0;
            bus.write_b   <= 1'b0;
            bus.in_b      <= 1'b0;
            bus.x_b       <= '0;
            bus.y_b       <= '0;
            rdata         <= 1'b0;
            x0_r          <= '0;
            x1_r          <= '0;
            y0_r          <= '0;
            y1_r          <= '0;
            op_r          <= '0;
        end else begin
            bus.read_b  <= 1'b0;
            bus.write_b <= 1'b0;
            bus.done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        x0_r          <= bus.cmd_x0;
                        x1_r          <= bus.cmd_x1;
                        y0_r          <= bus.cmd_y0;
                        y1_r          <= bus.cmd_y1;
                        op_r          <= bus.cmd_op;
                        bus.cmd_ready <= 1'b0;
                        bus.err       <= 1'b0;
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    if (reject) begin
                        bus.err  <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end else begin
                        bus.x_b <= x0_r;
                        bus.y_b <= y0_r;
                        if (op_r == 2'd2) begin
                            bus.read_b <= 1'b1;
                            state      <= READ;
                        end else begin
                            bus.write_b <= 1'b1;
                            bus.in_b    <= op_r[0];
                            state       <= WRITE;
                        end
                    end
                end
                READ: state <= RWAIT;
                RWAIT: begin
                    if (bus.rdy_b) begin
                        rdata       <= ~bus.out_b;
                        bus.in_b    <= ~bus.out_b;
                        bus.write_b <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: state <= WWAIT;
                WWAIT: begin
                    if (bus.rdy_b) state <= ADV;
                end
                ADV: begin
                    if (more) begin
                        if (bus.x_b < x1_r) begin
                            bus.x_b <= bus.x_b + 9'd1;
                        end else begin
                            bus.x_b <= x0_r;
                            bus.y_b <= bus.y_b + 8'd1;
                        end
                        if (op_r == 2'd2) begin
                            bus.read_b <= 1'b1;
                            state      <= READ;
                        end else begin
                            bus.write_b <= 1'b1;
                            bus.in_b    <= op_r[0];
                            state       <= WRITE;
                        end
                    end else begin
                        bus.done <= 1'b1;
                        bus.err  <= 1'b0;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    bus.err       <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_engine.sv
// Directed bench for fb_rect_engine with a behavioural RAM port B model
// and a queue of expected pixel accesses.
module tb_fb_rect_engine;
    localparam int TB_W = 64;
    localparam int TB_H = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fb_rect_engine_if bus();

    fb_rect_engine #(.FB_W(TB_W), .FB_H(TB_H)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit wr;
        int x;
        int y;
        bit d;
    } acc_t;

    acc_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   n_rd   = 0;
    int   n_wr   = 0;
    int   n_done = 0;
    int   lat    = 1;
    bit   spur   = 1'b0;
    bit   mem [TB_H][TB_W];
    int   pend = 0, cnt = 0, ax = 0, ay = 0;
    bit   pend_wr = 1'b0, post = 1'b0, ad = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RAM port B model: answers each strobe lat cycles later, optionally
    // throwing stray rdy_b pulses where the engine must ignore them.
    always @(negedge clk) begin
        acc_t e;
        if (reset) begin
            bus.rdy_b = 1'b0;
            bus.out_b = 1'b0;
            pend = 0;
            post = 1'b0;
        end else begin
            bus.rdy_b = post && spur;
            post = 1'b0;
            if (bus.done) n_done++;
            if (pend != 0) begin
                check("hold_addr", 32'({bus.x_b, bus.y_b, pend_wr & bus.in_b}),
                      32'({9'(ax), 8'(ay), ad}));
                cnt--;
                if (cnt <= 0) begin
                    bus.rdy_b = 1'b1;
                    if (ax < TB_W && ay < TB_H) begin
                        if (pend_wr) mem[ay][ax] = ad;
                        else bus.out_b = mem[ay][ax];
                    end
                    pend = 0;
                    post = 1'b1;
                end
            end
            if (bus.read_b || bus.write_b) begin
                check("excl_strobe", 32'(bus.read_b & bus.write_b), 32'd0);
                check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("access", 32'({bus.write_b, bus.x_b, bus.y_b, bus.write_b & bus.in_b}),
                          32'({e.wr, 9'(e.x), 8'(e.y), e.wr & e.d}));
                end
                if (bus.write_b) n_wr++;
                else n_rd++;
                pend    = 1;
                cnt     = lat;
                ax      = int'(bus.x_b);
                ay      = int'(bus.y_b);
                pend_wr = bus.write_b;
                ad      = bus.write_b & bus.in_b;
                if (spur && ax < TB_W && ay < TB_H) begin
                    bus.rdy_b = 1'b1;
                    bus.out_b = ~mem[ay][ax];
                end
            end
        end
    end

    task automatic push_exp(input int x0, input int x1, input int y0, input int y1, input int op);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                if (op == 2) begin
                    exp_q.push_back('{wr: 1'b0, x: x, y: y, d: 1'b0});
                    exp_q.push_back('{wr: 1'b1, x: x, y: y, d: ~mem[y][x]});
                end else begin
                    exp_q.push_back('{wr: 1'b1, x: x, y: y, d: op[0]});
                end
            end
        end
    endtask

    task automatic issue(input int x0, input int x1, input int y0, input int y1, input int op,
                         input string tag);
        int cyc;
        @(negedge clk);
        bus.cmd_x0    = 9'(x0);
        bus.cmd_x1    = 9'(x1);
        bus.cmd_y0    = 8'(y0);
        bus.cmd_y1    = 8'(y1);
        bus.cmd_op    = 2'(op);
        bus.cmd_valid = 1'b1;
        cyc = 0;
        while (!bus.cmd_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input int x0, input int x1, input int y0, input int y1, input int op,
                           input bit bad, input string tag);
        int wr0, rd0, d0, cyc, npix, budget;
        npix   = bad ? 0 : (x1 - x0 + 1) * (y1 - y0 + 1);
        budget = npix * (4 * lat + 8) + 20;
        if (!bad) push_exp(x0, x1, y0, y1, op);
        wr0 = n_wr;
        rd0 = n_rd;
        d0  = n_done;
        issue(x0, x1, y0, y1, op, tag);
        cyc = 1;
        while (!bus.done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_err"}, 32'(bus.err), 32'(bad));
        if (bad) check({tag, "_err_latency"}, 32'(cyc), 32'd2);
        #1;
        check({tag, "_writes"}, 32'(n_wr - wr0), 32'(npix));
        check({tag, "_reads"}, 32'(n_rd - rd0), (op == 2) ? 32'(npix) : 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_one_done"}, 32'(n_done - d0), 32'd1);
        check({tag, "_idle"}, 32'({bus.done, bus.cmd_ready}), 32'b01);
    endtask

    initial begin
        int k, cyc, d0, w0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = '0;
        bus.cmd_x1 = '0;
        bus.cmd_y0 = '0;
        bus.cmd_y1 = '0;
        bus.cmd_op = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({bus.cmd_ready, bus.done, bus.err, bus.read_b, bus.write_b,
                                 bus.in_b, bus.x_b, bus.y_b}), 32'({1'b1, 22'd0}));
        reset = 1'b0;

        run_cmd(TB_W - 1, TB_W - 1, TB_H - 1, TB_H - 1, 0, 1'b0, "corner_clear");
        run_cmd(0, TB_W - 1, 0, TB_H - 1, 1, 1'b0, "full_set");
        check("last_pixel_set", 32'(mem[TB_H - 1][TB_W - 1]), 32'd1);

        mem[3][6] = 1'b0;
        run_cmd(5, 6, 3, 3, 2, 1'b0, "invert_pair");
        check("invert_result", 32'({mem[3][5], mem[3][6]}), 32'b01);

        run_cmd(10, 9, 0, 0, 1, 1'b1, "err_x_order");
        run_cmd(0, 0, 0, TB_H, 1, 1'b1, "err_y_range");
        run_cmd(0, TB_W, 0, 0, 1, 1'b1, "err_x_range");
        run_cmd(0, 0, 5, 4, 0, 1'b1, "err_y_order");
        run_cmd(0, 0, 0, 0, 3, 1'b1, "err_op3");

        lat  = 8;
        spur = 1'b1;
        run_cmd(2, 4, 1, 2, 0, 1'b0, "slow_clear");

        lat = 2;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                mem[y][x] = 1'((x ^ y) & 1);
        run_cmd(0, 3, 0, 1, 2, 1'b0, "invert_block");
        check("invert_block_px", 32'({mem[0][0], mem[0][1], mem[1][0], mem[1][1]}), 32'b1001);

        // Abort a full clear at its 100th pixel write.
        lat  = 1;
        spur = 1'b0;
        push_exp(0, TB_W - 1, 0, TB_H - 1, 0);
        d0 = n_done;
        issue(0, TB_W - 1, 0, TB_H - 1, 0, "abort");
        k = 0;
        cyc = 0;
        while (k < 100 && cyc < 2000) begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus.write_b) k++;
        end
        check("abort_reached_px100", 32'(k), 32'd100);
        reset = 1'b1;
        #1;
        check("abort_reset_outs", 32'({bus.cmd_ready, bus.done, bus.err, bus.read_b, bus.write_b,
                                       bus.in_b, bus.x_b, bus.y_b}), 32'({1'b1, 22'd0}));
        exp_q.delete();
        w0 = n_wr;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        check("abort_no_writes", 32'(n_wr - w0), 32'd0);
        run_cmd(1, 2, 1, 2, 1, 1'b0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
